// File: rtl/data_mem_bus_ctrl.sv
// Data-memory controller: runs a MEM-stage load/store as 16-bit beats on a req/ack bus,
// stalling the pipeline until the access completes, aborts or is rejected as misaligned.
module data_mem_bus_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic [63:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        align_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [1:0]  bus_be,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

    state_t      state_q;
    logic [63:0] addr_q, wdata_q, asm_q, read_data_q, bus_addr_q;
    logic        byte_q, we_q, done_q, align_err_q, timeout_err_q, bus_req_q, bus_we_q;
    logic [1:0]  beat_q, bus_be_q;
    logic [9:0]  wait_q;
    logic [15:0] bus_wdata_q;

    logic        req_in, byte_in, last_beat;
    logic [1:0]  beat_nxt;
    logic [63:0] asm_d;

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic is_byte,
                                              input logic [1:0] b);
        return is_byte ? a : a + {61'd0, b, 1'b0};
    endfunction

    function automatic logic [1:0] beat_be(input logic a0, input logic is_byte);
        return is_byte ? (a0 ? 2'b10 : 2'b01) : 2'b11;
    endfunction

    function automatic logic [15:0] beat_wdata(input logic [63:0] d, input logic a0,
                                               input logic is_byte, input logic [1:0] b);
        if (is_byte)
            return a0 ? {d[7:0], 8'h00} : {8'h00, d[7:0]};
        return d[{b, 4'b0000} +: 16];
    endfunction

    assign req_in    = read_enable | write_enable;
    assign byte_in   = (xfer_size == 4'b0001);
    assign last_beat = byte_q | (beat_q == 2'd3);
    assign beat_nxt  = beat_q + 2'd1;

    // Assembly word as it will look once the current read beat is accepted.
    always_comb begin
        asm_d = asm_q;
        if (byte_q)
            asm_d = {56'd0, addr_q[0] ? bus_rdata[15:8] : bus_rdata[7:0]};
        else
            asm_d[{beat_q, 4'b0000} +: 16] = bus_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            asm_q         <= '0;
            read_data_q   <= '0;
            byte_q        <= 1'b0;
            we_q          <= 1'b0;
            beat_q        <= '0;
            wait_q        <= '0;
            done_q        <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= 2'b00;
            bus_wdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (req_in) begin
                    addr_q  <= address;
                    wdata_q <= write_data;
                    byte_q  <= byte_in;
                    we_q    <= write_enable;
                    beat_q  <= '0;
                    wait_q  <= '0;
                    asm_q   <= '0;
                    if (!byte_in && address[0]) begin
                        align_err_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= write_enable;
                        bus_addr_q  <= beat_addr(address, byte_in, 2'd0);
                        bus_be_q    <= beat_be(address[0], byte_in);
                        bus_wdata_q <= beat_wdata(write_data, address[0], byte_in, 2'd0);
                        state_q     <= BEAT;
                    end
                end
                BEAT: if (bus_ack) begin
                    asm_q  <= asm_d;
                    beat_q <= beat_nxt;
                    wait_q <= '0;
                    if (last_beat) begin
                        if (!we_q)
                            read_data_q <= asm_d;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        bus_addr_q  <= beat_addr(addr_q, byte_q, beat_nxt);
                        bus_wdata_q <= beat_wdata(wdata_q, addr_q[0], byte_q, beat_nxt);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    if (!we_q)
                        read_data_q <= '1;
                    timeout_err_q <= 1'b1;
                    bus_req_q     <= 1'b0;
                    bus_we_q      <= 1'b0;
                    done_q        <= 1'b1;
                    state_q       <= DONE;
                end else begin
                    wait_q <= wait_q + 10'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only IDLE looks at the enables; DONE never stalls so the pipeline advances there.
    assign stall       = (state_q == BEAT) | ((state_q == IDLE) & req_in);
    assign done        = done_q;
    assign read_data   = read_data_q;
    assign align_err   = align_err_q;
    assign timeout_err = timeout_err_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
endmodule

// File: tb/tb_data_mem_bus_ctrl.sv
// Scoreboard bench for data_mem_bus_ctrl: directed accesses against a byte-array bus memory,
// with expected completions and expected bus beats checked by independent monitor processes.
module tb_data_mem_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] address = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [63:0] write_data = '0;
    logic [3:0]  xfer_size = '0;
    logic [63:0] read_data;
    logic        stall, done, align_err, timeout_err, bus_req, bus_we;
    logic [63:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    always #5 clk = ~clk;

    data_mem_bus_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .address(address), .read_enable(read_enable),
        .write_enable(write_enable), .write_data(write_data), .xfer_size(xfer_size),
        .read_data(read_data), .stall(stall), .done(done), .align_err(align_err),
        .timeout_err(timeout_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        logic [63:0] rd;
        logic        aerr;
        logic        terr;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wd;
    } beat_t;

    exp_t  exp_q[$];
    beat_t bq[$];
    int    n_tests = 0;
    int    n_fail = 0;
    logic [7:0] mem [0:255];
    int    dly [4];
    bit    never_ack = 1'b0;
    int    beat_idx = 0;
    int    wcnt = 0;
    bit    started = 1'b0;
    beat_t cap;
    int    scnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input logic [63:0] a, input logic [1:0] be, input logic we,
                             input logic [15:0] wd);
        beat_t b;
        b.a = a; b.be = be; b.we = we; b.wd = wd;
        bq.push_back(b);
    endtask

    task automatic issue(input logic re, input logic we, input logic [63:0] a,
                         input logic [63:0] d, input logic [3:0] sz, input logic [63:0] rd,
                         input logic aerr, input logic terr, input int stalls);
        exp_t e;
        int   n;
        e.rd = rd; e.aerr = aerr; e.terr = terr; e.stalls = stalls;
        exp_q.push_back(e);
        @(posedge clk); #1;
        read_enable = re; write_enable = we; address = a; write_data = d; xfer_size = sz;
        @(posedge clk); #1;
        read_enable = 1'b0; write_enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    // Bus slave: drives ack/rdata at negedge; a beat acked at the previous negedge was taken
    // by the DUT on the posedge in between, so it is committed here.
    always @(negedge clk) begin : responder
        logic [7:0] base;
        if (!reset) begin
            bus_ack = 1'b0; wcnt = 0; beat_idx = 0; started = 1'b0;
        end else begin
            if (bus_ack) begin
                if (bq.size() == 0) begin
                    check("beat_extra", 64'd1, 64'd0);
                end else begin
                    beat_t b;
                    b = bq.pop_front();
                    check("beat_addr", cap.a, b.a);
                    check("beat_be", {62'd0, cap.be}, {62'd0, b.be});
                    check("beat_we", {63'd0, cap.we}, {63'd0, b.we});
                    if (b.we) check("beat_wdata", {48'd0, cap.wd}, {48'd0, b.wd});
                end
                if (cap.we) begin
                    base = {cap.a[7:1], 1'b0};
                    if (cap.be[0]) mem[base] = cap.wd[7:0];
                    if (cap.be[1]) mem[base + 8'd1] = cap.wd[15:8];
                end
                beat_idx++; wcnt = 0; started = 1'b0;
            end
            if (!bus_req) beat_idx = 0;
            if (bus_req && !never_ack) begin
                if (!started) begin
                    cap.a = bus_addr; cap.be = bus_be; cap.we = bus_we; cap.wd = bus_wdata;
                    started = 1'b1;
                end else begin
                    check("hold_addr", bus_addr, cap.a);
                    check("hold_be", {62'd0, bus_be}, {62'd0, cap.be});
                end
                if (wcnt >= dly[beat_idx & 3]) begin
                    base = {bus_addr[7:1], 1'b0};
                    bus_ack = 1'b1;
                    bus_rdata = {mem[base + 8'd1], mem[base]};
                end else begin
                    bus_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            scnt = 0;
        end else begin
            if (stall) scnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", read_data, e.rd);
                    check("align_err", {63'd0, align_err}, {63'd0, e.aerr});
                    check("timeout_err", {63'd0, timeout_err}, {63'd0, e.terr});
                    check("stall_cycles", 64'(scnt), 64'(e.stalls));
                    check("stall_in_done", {63'd0, stall}, 64'd0);
                end
                scnt = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) dly[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {56'd0, stall, done, bus_req, bus_we, align_err, timeout_err, bus_be},
              64'd0);
        check("rst_rdata", read_data, 64'd0);
        check("rst_baddr", bus_addr, 64'd0);
        check("rst_bwdata", {48'd0, bus_wdata}, 64'd0);

        // 8-byte write then read, zero-wait
        push_beat(64'h40, 2'b11, 1'b1, 16'hCDEF);
        push_beat(64'h42, 2'b11, 1'b1, 16'h89AB);
        push_beat(64'h44, 2'b11, 1'b1, 16'h4567);
        push_beat(64'h46, 2'b11, 1'b1, 16'h0123);
        issue(1'b0, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, 4'b1000, 64'd0, 1'b0, 1'b0, 5);
        for (int i = 0; i < 4; i++) push_beat(64'h40 + 64'(2 * i), 2'b11, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 64'h40, 64'h0, 4'b1000, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 5);

        // byte write / read on odd address
        push_beat(64'h41, 2'b10, 1'b1, 16'hA500);
        issue(1'b0, 1'b1, 64'h41, 64'h11A5, 4'b0001, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 2);
        push_beat(64'h41, 2'b10, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 64'h41, 64'h0, 4'b0001, 64'h0000_0000_0000_00A5, 1'b0, 1'b0, 2);

        // 3 wait states on beat 2
        dly[2] = 3;
        for (int i = 0; i < 4; i++) push_beat(64'h40 + 64'(2 * i), 2'b11, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 64'h40, 64'h0, 4'b1000, 64'h0123_4567_89AB_A5EF, 1'b0, 1'b0, 8);
        dly[2] = 0;

        // both enables: write wins, read_data untouched
        push_beat(64'h60, 2'b11, 1'b1, 16'hF00D);
        push_beat(64'h62, 2'b11, 1'b1, 16'hCAFE);
        push_beat(64'h64, 2'b11, 1'b1, 16'hBEEF);
        push_beat(64'h66, 2'b11, 1'b1, 16'hDEAD);
        issue(1'b1, 1'b1, 64'h60, 64'hDEAD_BEEF_CAFE_F00D, 4'b1000, 64'h0123_4567_89AB_A5EF,
              1'b0, 1'b0, 5);

        // timeout, then sticky timeout_err on a good access
        never_ack = 1'b1;
        issue(1'b1, 1'b0, 64'h80, 64'h0, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5);
        never_ack = 1'b0;
        push_beat(64'h60, 2'b01, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 64'h60, 64'h0, 4'b0001, 64'h0000_0000_0000_000D, 1'b0, 1'b1, 2);

        // misaligned 8-byte read: no beats, done in cycle 1
        issue(1'b1, 1'b0, 64'h43, 64'h0, 4'b1000, 64'h0000_0000_0000_000D, 1'b1, 1'b1, 1);

        // reset during beat 2
        dly[2] = 2;
        push_beat(64'h40, 2'b11, 1'b0, 16'h0);
        push_beat(64'h42, 2'b11, 1'b0, 16'h0);
        @(posedge clk); #1;
        read_enable = 1'b1; address = 64'h40; xfer_size = 4'b1000;
        @(posedge clk); #1;
        read_enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(beat_idx == 2 && bus_req) && n < 20);
        check("rst_mid_reach", {63'd0, bus_req}, 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_async", {61'd0, bus_req, stall, done}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_nodone", {63'd0, done}, 64'd0);
        end
        reset = 1'b1;
        dly[2] = 0;
        @(negedge clk);
        check("rst_mid_clr", {61'd0, align_err, timeout_err, bus_req}, 64'd0);
        check("rst_mid_rdata", read_data, 64'd0);

        for (int i = 0; i < 4; i++) push_beat(64'h40 + 64'(2 * i), 2'b11, 1'b0, 16'h0);
        issue(1'b1, 1'b0, 64'h40, 64'h0, 4'b1000, 64'h0123_4567_89AB_A5EF, 1'b0, 1'b0, 5);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("beat_q_empty", 64'(bq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
